axis_red_pitaya_adc_dec: RTL
============================

# axis_red_pitaya_adc_dec

Two-channel Red Pitaya ADC front end with a programmable boxcar decimator, between the ADC pins and downstream AXI4-Stream DSP. Each cycle it captures both ADC lanes, converts the inverted offset-binary samples to two's complement, sums a programmable number of samples per channel, scales and saturates each sum, and emits one packed {B,A} word per window with full tvalid/tready flow control. It also reports sticky per-channel overrange flags and counts results dropped under backpressure.

## Interface
- ADC_DATA_WIDTH, 14: valid ADC bits, MSB-aligned in the 16-bit pin bus (range 2..16).
- CNTR_WIDTH, 16: width of the decimation ratio and window counter.
- aclk  in  1  sole clock.
- aresetn  in  1  asynchronous, active-low reset.
- adc_csn  out  1  tied 1.
- adc_dat_a, adc_dat_b  in  16  raw ADC buses; the valid field is [15:16-ADC_DATA_WIDTH].
- cfg_enable  in  1  run decimator when 1.
- cfg_ratio  in  CNTR_WIDTH  samples per window; 0 and 1 both mean 1.
- cfg_shift  in  5  arithmetic right shift applied to each sum.
- cfg_clear  in  1  clears sts_ovr.
- sts_ovr  out  2  sticky overrange, [0]=A, [1]=B.
- sts_drop  out  32  saturating count of dropped results.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  result valid.
- m_axis_tdata  out  32  {lane B[15:0], lane A[15:0]}, signed.

## Operation
- Conversion: take field x = adc_dat[15:16-W] with W = ADC_DATA_WIDTH. Form s = {x[W-1], ~x[W-2:0]}, a W-bit signed value, and sign-extend it.
- Overrange: sts_ovr[ch] sets when s equals +(2^(W-1)-1) or -2^(W-1).
  - It clears on cfg_clear.
  - If set and clear occur on the same edge, set wins.
- Window:
  - The counter cnt runs 0..R-1.
  - At cnt==0, latch R = max(cfg_ratio,1) and the current cfg_shift. Config changes mid-window take effect at the next window.
  - The accumulator is signed, W+CNTR_WIDTH bits wide, and cannot overflow. At cnt==0 it loads s; otherwise it adds s.
  - At cnt==R-1 the window is done and cnt returns to 0.
- Result per lane: acc >>> shift (arithmetic), then saturate to [-32768, 32767].
- cfg_enable=0:
  - cnt and acc clear and the partial window is discarded.
  - No new results are produced.
  - A pending output remains valid until it is accepted.
- Output register, on an edge where a result is ready:
  - If tvalid=0 or tready=1: load the result and set tvalid=1.
  - Otherwise: hold tdata and increment sts_drop, saturating at 2^32-1.
- With no result ready on an edge: tvalid & tready gives tvalid=0.
- tdata is stable while tvalid=1 and tready=0.

## Timing
- Reset values: tvalid 0, tdata 0, sts_ovr 0, sts_drop 0, cnt 0, acc 0. adc_csn is constant 1.
- The reset takes effect immediately on aresetn falling, including mid-window or mid-handshake. After release, the first window starts with the first captured sample.
- Pipeline: raw capture at edge k, then accumulator, counter and done flag at k+1, then output register at k+2.
  - With R=1, the sample present at edge k is visible on tdata with tvalid=1 after edge k+2.
  - With R>1, the result appears 2 edges after the window's last sample.
- Throughput: one result per R cycles, with no bubbles at R=1 when tready=1.
- sts_ovr updates one edge after capture (k+1).

## Test plan
- Conversion, R=1, shift 0, tready=1: A=16'h0000 and B=16'hFFFC give tdata=32'hE000_1FFF, with tvalid high 2 edges after capture and every cycle thereafter.
- Decimation, R=4, shift 2, A constant 16'h8000 (s=-1): tdata[15:0]=16'hFFFF, one tvalid beat per 4 cycles. Changing cfg_ratio mid-window does not alter the current window's length.
- Saturation, R=8, shift 0, A=16'h0000 (s=8191, sum 65528): lane A=16'h7FFF. Shift 3 gives 16'h1FFF.
- Backpressure, R=1, tready=0 for 10 results:
  - tdata holds the first result and sts_drop=9.
  - Raising tready with a new result on the same edge loads it with no drop and tvalid stays 1.
- Overrange and enable:
  - A=16'hFFFC sets sts_ovr[0].
  - cfg_clear coincident with another overrange sample leaves sts_ovr[0] set.
  - cfg_enable=0 mid-window discards the partial sum, and the next output covers a full fresh window.
- Asynchronous reset asserted between edges while tvalid=1: tvalid, tdata and the status outputs go to 0 before the next edge.

Source files
------------

// File: rtl/axis_red_pitaya_adc_dec_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_red_pitaya_adc_dec_if
// Brief    : AXI4-Stream master/slave bundle for the decimated ADC output.
// Revision : 1.0
// ============================================================================
interface axis_red_pitaya_adc_dec_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_red_pitaya_adc_dec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_red_pitaya_adc_dec
// Brief    : Two-lane Red Pitaya ADC capture with boxcar decimation and AXIS out.
// Revision : 1.0
// ============================================================================
module axis_red_pitaya_adc_dec #(
    parameter int ADC_DATA_WIDTH = 14,
    parameter int CNTR_WIDTH     = 16
) (
    input  wire logic                  aclk,
    input  wire logic                  aresetn,
    output logic                       adc_csn,
    input  wire logic [15:0]           adc_dat_a,
    input  wire logic [15:0]           adc_dat_b,
    input  wire logic                  cfg_enable,
    input  wire logic [CNTR_WIDTH-1:0] cfg_ratio,
    input  wire logic [4:0]            cfg_shift,
    input  wire logic                  cfg_clear,
    output logic [1:0]                 sts_ovr,
    output logic [31:0]                sts_drop,
    axis_red_pitaya_adc_dec_if.master  m_axis
);
    localparam int c_acc_width = ADC_DATA_WIDTH + CNTR_WIDTH;
    localparam int c_ext_width = c_acc_width + 16;

    logic [1:0][15:0]      w_pin;
    logic [1:0][15:0]      w_res;
    logic                  r_cap_vld;
    logic [CNTR_WIDTH-1:0] r_cnt;
    logic [CNTR_WIDTH-1:0] r_ratio;
    logic [4:0]            r_shift;
    logic                  r_done;
    logic                  r_tvalid;
    logic [31:0]           r_tdata;
    logic [31:0]           r_drop;
    logic                  w_first;
    logic                  w_last;
    logic                  w_step;
    logic [CNTR_WIDTH-1:0] w_ratio_in;

    assign adc_csn  = 1'b1;
    assign w_pin[0] = adc_dat_a;
    assign w_pin[1] = adc_dat_b;

    // r_cap_vld keeps the post-reset capture register out of the first window.
    assign w_step     = r_cap_vld & cfg_enable;
    assign w_first    = (r_cnt == '0);
    assign w_ratio_in = (cfg_ratio == '0) ? CNTR_WIDTH'(1) : cfg_ratio;
    assign w_last     = w_first ? (w_ratio_in == CNTR_WIDTH'(1))
                                : (r_cnt == r_ratio - CNTR_WIDTH'(1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cap_vld <= 1'b0;
            r_cnt     <= '0;
            r_ratio   <= '0;
            r_shift   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_cap_vld <= 1'b1;
            r_done    <= w_step & w_last;
            if (!cfg_enable) begin
                r_cnt <= '0;
            end else if (w_step) begin
                if (w_first) begin
                    r_ratio <= w_ratio_in;
                    r_shift <= cfg_shift;
                end
                r_cnt <= w_last ? '0 : r_cnt + CNTR_WIDTH'(1);
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam logic signed [ADC_DATA_WIDTH-1:0] c_s_max = {1'b0, {(ADC_DATA_WIDTH-1){1'b1}}};
        localparam logic signed [ADC_DATA_WIDTH-1:0] c_s_min = {1'b1, {(ADC_DATA_WIDTH-1){1'b0}}};
        localparam logic signed [c_ext_width-1:0]    c_pos   = c_ext_width'(32767);
        localparam logic signed [c_ext_width-1:0]    c_neg   = c_ext_width'(-32768);

        logic [ADC_DATA_WIDTH-1:0]        r_raw;
        logic signed [ADC_DATA_WIDTH-1:0] w_s;
        logic signed [c_acc_width-1:0]    w_s_ext;
        logic signed [c_acc_width-1:0]    r_acc;
        logic signed [c_ext_width-1:0]    w_shifted;
        logic                             r_ovr;

        // Pins carry inverted offset-binary: keep the MSB, flip the rest.
        assign w_s       = {r_raw[ADC_DATA_WIDTH-1], ~r_raw[ADC_DATA_WIDTH-2:0]};
        assign w_s_ext   = c_acc_width'(w_s);
        assign w_shifted = c_ext_width'(r_acc) >>> r_shift;
        assign w_res[g]  = (w_shifted > c_pos) ? 16'h7FFF :
                           (w_shifted < c_neg) ? 16'h8000 : w_shifted[15:0];
        assign sts_ovr[g] = r_ovr;

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_raw <= '0;
                r_acc <= '0;
                r_ovr <= 1'b0;
            end else begin
                r_raw <= w_pin[g][15 -: ADC_DATA_WIDTH];
                if (!cfg_enable) begin
                    r_acc <= '0;
                end else if (w_step) begin
                    r_acc <= w_first ? w_s_ext : r_acc + w_s_ext;
                end
                if (r_cap_vld && ((w_s == c_s_max) || (w_s == c_s_min))) begin
                    r_ovr <= 1'b1;
                end else if (cfg_clear) begin
                    r_ovr <= 1'b0;
                end
            end
        end
    end

    if (ADC_DATA_WIDTH < 16) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = &{1'b0, adc_dat_a[15-ADC_DATA_WIDTH:0], adc_dat_b[15-ADC_DATA_WIDTH:0]};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_drop   <= '0;
        end else if (r_done) begin
            if (!r_tvalid || m_axis.tready) begin
                r_tdata  <= {w_res[1], w_res[0]};
                r_tvalid <= 1'b1;
            end else if (r_drop != '1) begin
                r_drop <= r_drop + 32'd1;
            end
        end else if (m_axis.tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign sts_drop      = r_drop;
endmodule
`default_nettype wire
